// File: rtl/column_result_drain_pkg.sv
// Shared definitions for the column result drain.
//   - FSM state encoding (IDLE / SEND)
//   - default geometry constants (lanes, accumulator width, output width, shift width)
//   - lane_slice(): extracts one accumulator lane from the packed column bus
package column_result_drain_pkg;

    localparam int LANES   = 16;
    localparam int ACC_W   = 28;
    localparam int OUT_W   = 16;
    localparam int SHIFT_W = 5;
    localparam int PTR_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Lane k lives in bits [ACC_W*k +: ACC_W]; lane 0 is the first PE of the column.
    function automatic logic [ACC_W-1:0] lane_slice(input logic [LANES*ACC_W-1:0] bus,
                                                    input logic [PTR_W-1:0]       k);
        return bus[int'(k)*ACC_W +: ACC_W];
    endfunction

endpackage

// File: rtl/column_result_drain_result_requant.sv
// result_requant: purely combinational requantizer.
//   acc_i   : signed ACC_W-bit accumulator value
//   shift_i : arithmetic right-shift amount (sign-filled, floor rounding)
//   data_o  : shifted value saturated to a signed OUT_W-bit word
module result_requant #(
    parameter int ACC_W   = 28,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [OUT_W-1:0]   data_o
);

    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-OUT_W:0]    upper;

    // Shifts beyond ACC_W-1 leave only sign bits, giving 0 or -1.
    assign shifted = $signed(acc_i) >>> shift_i;

    // The value fits in OUT_W bits exactly when every bit from the output
    // sign position upward is a copy of the sign.
    assign upper = shifted[ACC_W-1:OUT_W-1];

    always_comb begin
        data_o = shifted[OUT_W-1:0];
        if (!((&upper) || (~|upper))) begin
            if (shifted[ACC_W-1]) begin
                data_o = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                data_o = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/column_result_drain.sv
// column_result_drain: snapshots the 16 accumulator lanes of a BitFusion
// column on a capture strobe and streams them, requantized, one lane per
// transfer to the output buffer.
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   capture, shift  : snapshot strobe and the shift amount latched with it
//   col_outputs     : packed column accumulators
//   out_data/out_lane/out_last/out_valid, out_ready : output stream
//   busy            : snapshot not yet fully drained
//   overrun         : sticky, a capture arrived while draining and was dropped
//   dbg_state       : current FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// presented word, lane and last flag hold steady.
module column_result_drain
    import column_result_drain_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic [SHIFT_W-1:0]     shift,
    input  logic [LANES*ACC_W-1:0] col_outputs,
    output logic [OUT_W-1:0]       out_data,
    output logic [PTR_W-1:0]       out_lane,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun,
    output logic                   dbg_state
);

    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               overrun_q;
    logic [ACC_W-1:0]   bank_q [LANES];

    logic               handshake;
    logic               final_hs;
    logic               load_bank;
    logic [OUT_W-1:0]   req_data;

    assign handshake = (state_q == ST_SEND) && out_ready;
    assign final_hs  = handshake && (ptr_q == LAST_LANE);
    // The bank reloads from IDLE, or on the last handshake for a
    // back-to-back snapshot with no bubble.
    assign load_bank = reset && capture && ((state_q == ST_IDLE) || final_hs);

    // Shadow bank is deliberately not reset; its contents are only
    // observable after a capture has loaded it.
    always_ff @(posedge clk) begin
        if (load_bank) begin
            for (int k = 0; k < LANES; k++) begin
                bank_q[k] <= lane_slice(col_outputs, PTR_W'(k));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q <= ST_SEND;
                        ptr_q   <= '0;
                        shift_q <= shift;
                    end
                end
                ST_SEND: begin
                    if (capture && !final_hs) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (ptr_q != LAST_LANE) begin
                            ptr_q <= ptr_q + 1'b1;
                        end else begin
                            ptr_q <= '0;
                            if (capture) begin
                                shift_q <= shift;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    result_requant #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT_W(SHIFT_W)
    ) u_requant (
        .acc_i  (bank_q[ptr_q]),
        .shift_i(shift_q),
        .data_o (req_data)
    );

    assign out_valid = (state_q == ST_SEND);
    assign busy      = out_valid;
    assign out_lane  = ptr_q;
    assign out_last  = out_valid && (ptr_q == LAST_LANE);
    // Forced to zero outside SEND so an un-loaded bank never leaks out.
    assign out_data  = out_valid ? req_data : '0;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_column_result_drain.sv
module tb_column_result_drain;

    localparam int NL = 16;
    localparam int AW = 28;
    localparam int OW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              capture;
    logic [4:0]        shift;
    logic [NL*AW-1:0]  col_outputs;
    logic [OW-1:0]     out_data;
    logic [3:0]        out_lane;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overrun;
    logic              dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] bank_in [NL];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] rd_q[$];
    logic [3:0]    rl_q[$];
    logic          rlast_q[$];
    int            rc_q[$];

    column_result_drain dut (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .shift      (shift),
        .col_outputs(col_outputs),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Records every accepted word (valid & ready seen mid-cycle => transfer at next edge).
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            rd_q.push_back(out_data);
            rl_q.push_back(out_lane);
            rlast_q.push_back(out_last);
            rc_q.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    // Floor division by 2^sh of the signed lane value, then clamp to the output range.
    function automatic logic [OW-1:0] ref_q(input logic [AW-1:0] x, input int sh);
        longint v;
        longint s;
        v = $signed(x);
        s = v >>> sh;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[OW-1:0];
    endfunction

    function automatic logic [NL*AW-1:0] pack_bank();
        logic [NL*AW-1:0] p;
        for (int k = 0; k < NL; k++) p[k*AW +: AW] = bank_in[k];
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_rec();
        rd_q.delete(); rl_q.delete(); rlast_q.delete(); rc_q.delete(); exp_q.delete();
    endtask

    task automatic push_exp(input int sh);
        for (int k = 0; k < NL; k++) exp_q.push_back(ref_q(bank_in[k], sh));
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < NL; k++) col_outputs[k*AW +: AW] = AW'($urandom);
        shift = 5'($urandom);
    endtask

    task automatic do_capture(input int sh);
        @(posedge clk); #1;
        col_outputs = pack_bank();
        shift       = 5'(sh);
        capture     = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic wait_lane(input string name, input int lane);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_lane == 4'(lane)) && n < 100);
        if (!(out_valid && out_lane == 4'(lane))) begin
            checks++;
            errors++;
            $display("FAIL %s_lane_wait: lane=%0d valid=%b, required lane %0d", name, out_lane, out_valid, lane);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; capture = 1'b0; out_ready = 1'b1; scramble_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last: got %b required 0", out_last); end
        checks++; if (out_lane !== 4'd0)  begin errors++; $display("FAIL reset_lane: got %0d required 0", out_lane); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %h required 0", out_data); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic_drain();
        clear_rec();
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) bank_in[k] = AW'(k * 1000);
        push_exp(0);
        do_capture(0);
        wait_idle("basic", 40);
        checks++; if (rd_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d required %0d", rd_q.size(), exp_q.size()); end
        for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i % NL) || rlast_q[i] !== (i % NL == NL - 1)) begin
                errors++;
                $display("FAIL basic_word[%0d]: got data=%h lane=%0d last=%b required data=%h lane=%0d last=%b",
                         i, rd_q[i], rl_q[i], rlast_q[i], exp_q[i], i % NL, (i % NL == NL - 1));
            end
            if (i > 0) begin
                checks++;
                if (rc_q[i] - rc_q[i-1] != 1) begin errors++; $display("FAIL basic_gap[%0d]: got %0d cycles required 1", i, rc_q[i] - rc_q[i-1]); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] want [4];
        want[0] = 16'h7FFF; want[1] = 16'h8000; want[2] = 16'hFFF6; want[3] = 16'd10000;
        clear_rec();
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        bank_in[0] = 28'h7FFFFFF;
        bank_in[1] = 28'h8000000;
        bank_in[2] = 28'hFFFFFD8;   // -40
        bank_in[3] = 28'd40000;
        push_exp(2);
        do_capture(2);
        wait_idle("sat", 40);
        checks++; if (rd_q.size() != NL) begin errors++; $display("FAIL sat_count: got %0d required %0d", rd_q.size(), NL); end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== want[i]) begin errors++; $display("FAIL sat_const[%0d]: got %h required %h", i, rd_q[i], want[i]); end
        end
        for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i)) begin
                errors++; $display("FAIL sat_word[%0d]: got data=%h lane=%0d required data=%h lane=%0d", i, rd_q[i], rl_q[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        bit            pat [4];
        bit            stalled = 1'b0;
        logic [OW-1:0] hold_d;
        logic [3:0]    hold_l;
        logic          hold_last;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        clear_rec();
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        push_exp(7);
        do_capture(7);
        for (int i = 0; i < 200; i++) begin
            out_ready = pat[i % 4];
            @(negedge clk);
            if (!busy) break;
            if (stalled) begin
                checks++;
                if (out_data !== hold_d || out_lane !== hold_l || out_last !== hold_last || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold: got data=%h lane=%0d last=%b valid=%b required data=%h lane=%0d last=%b valid=1",
                             out_data, out_lane, out_last, out_valid, hold_d, hold_l, hold_last);
                end
            end
            stalled   = out_valid && !out_ready;
            hold_d    = out_data;
            hold_l    = out_lane;
            hold_last = out_last;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle("bp", 5);
        checks++; if (rd_q.size() != NL) begin errors++; $display("FAIL bp_count: got %0d required %0d", rd_q.size(), NL); end
        for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i) || rlast_q[i] !== (i == NL - 1)) begin
                errors++; $display("FAIL bp_word[%0d]: got data=%h lane=%0d last=%b required data=%h lane=%0d", i, rd_q[i], rl_q[i], rlast_q[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_rec();
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) bank_in[k] = AW'(k * 37 + 5);
        push_exp(1);
        do_capture(1);
        wait_lane("b2b", NL - 1);
        // Second capture coincides with the lane-15 handshake.
        for (int k = 0; k < NL; k++) bank_in[k] = AW'(-k);
        push_exp(0);
        col_outputs = pack_bank();
        shift       = 5'd0;
        capture     = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        scramble_inputs();
        wait_idle("b2b", 40);
        checks++; if (rd_q.size() != 2 * NL) begin errors++; $display("FAIL b2b_count: got %0d required %0d", rd_q.size(), 2 * NL); end
        for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i % NL) || rlast_q[i] !== (i % NL == NL - 1)) begin
                errors++; $display("FAIL b2b_word[%0d]: got data=%h lane=%0d last=%b required data=%h lane=%0d", i, rd_q[i], rl_q[i], rlast_q[i], exp_q[i], i % NL);
            end
            if (i > 0) begin
                checks++;
                if (rc_q[i] - rc_q[i-1] != 1) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles required 1", i, rc_q[i] - rc_q[i-1]); end
            end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b required 0", overrun); end
    endtask

    task automatic test_overrun();
        clear_rec();
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        push_exp(3);
        do_capture(3);
        wait_lane("ovr", 5);
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        col_outputs = pack_bank();
        shift       = 5'd0;
        capture     = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        scramble_inputs();
        @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", overrun); end
        wait_idle("ovr", 40);
        checks++; if (rd_q.size() != NL) begin errors++; $display("FAIL ovr_count: got %0d required %0d", rd_q.size(), NL); end
        for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i)) begin
                errors++; $display("FAIL ovr_word[%0d]: got data=%h lane=%0d required data=%h lane=%0d", i, rd_q[i], rl_q[i], exp_q[i], i);
            end
        end
        // A clean drain afterwards must not clear the sticky flag.
        clear_rec();
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        push_exp(12);
        do_capture(12);
        wait_idle("ovr2", 40);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
        checks++; if (rd_q.size() != NL || rd_q[NL-1] !== exp_q[NL-1]) begin
            errors++; $display("FAIL ovr2_stream: got %0d words, last=%h required %0d words, last=%h", rd_q.size(), (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 16'hx, NL, exp_q[NL-1]);
        end
    endtask

    task automatic test_reset_midstream();
        clear_rec();
        out_ready = 1'b1;
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        push_exp(4);
        do_capture(4);
        wait_lane("rst", 6);
        @(posedge clk); #1;
        reset = 1'b0;          // asserted while lane 7 is presented
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rst_overrun: got %b required 0", overrun); end
        checks++; if (rd_q.size() != 7)   begin errors++; $display("FAIL rst_count: got %0d required 7", rd_q.size()); end
        @(posedge clk); #1;
        reset = 1'b1;
        clear_rec();
        for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
        push_exp(9);
        do_capture(9);
        wait_idle("rst", 40);
        checks++; if (rd_q.size() != NL) begin errors++; $display("FAIL rst_restart_count: got %0d required %0d", rd_q.size(), NL); end
        for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i)) begin
                errors++; $display("FAIL rst_word[%0d]: got data=%h lane=%0d required data=%h lane=%0d", i, rd_q[i], rl_q[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int sh;
            int n;
            clear_rec();
            sh = $urandom_range(0, 31);
            for (int k = 0; k < NL; k++) bank_in[k] = AW'($urandom);
            push_exp(sh);
            do_capture(sh);
            n = 0;
            while (busy && n < 200) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                @(posedge clk); #1;
                n++;
            end
            out_ready = 1'b1;
            wait_idle("rand", 5);
            checks++; if (rd_q.size() != NL) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", r, rd_q.size(), NL); end
            for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (rd_q[i] !== exp_q[i] || rl_q[i] !== 4'(i) || rlast_q[i] !== (i == NL - 1)) begin
                    errors++; $display("FAIL rand%0d_word[%0d]: got data=%h lane=%0d last=%b required data=%h lane=%0d (shift %0d)",
                                       r, i, rd_q[i], rl_q[i], rlast_q[i], exp_q[i], i, sh);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_drain();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_midstream();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
